// File: rtl/br_ctrl_pkg.sv
// Shared types and constants for the branch-unit sequencer (br_ctrl) and its
// watchdog helper.
package br_ctrl_pkg;

  localparam int BRSEL_WIDTH = 2;

  typedef enum logic [BRSEL_WIDTH-1:0] {
    BRSEL_NONE  = 2'd0,
    BRSEL_PCREL = 2'd1,
    BRSEL_REG   = 2'd2
  } brsel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRIG = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } br_state_e;

  typedef struct packed {
    logic [BRSEL_WIDTH-1:0] brsel;
    logic [63:0]            pc;
    logic [63:0]            rs1;
    logic [63:0]            imm;
  } br_req_t;

  localparam logic [63:0] INSN_BYTES = 64'd4;

  // Fall-through address of a branch; wraps modulo 2^64.
  function automatic logic [63:0] link_addr(input logic [63:0] pc);
    return pc + INSN_BYTES;
  endfunction

endpackage

// File: rtl/br_ctrl_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting on the branch unit and
// raises a sticky error when WAIT_MAX cycles pass without a response.
module br_ctrl_wdog
  import br_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire,
  output logic err
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;

  // Fires in the last permitted WAIT cycle, so WAIT never lasts longer than WAIT_MAX.
  assign expire = en && (cnt_q == CNT_W'(WAIT_MAX - 1));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      if (clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (expire) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_ctrl.sv
// Execute-stage sequencer around the branch unit: latches one op, triggers br,
// waits for its result, and hands link/taken/target to writeback and fetch.
module br_ctrl
  import br_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 4,
  parameter int EPOCH_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BRSEL_WIDTH-1:0] in_brsel,
  input  logic [63:0]            in_pc,
  input  logic [63:0]            in_rs1,
  input  logic [63:0]            in_imm,
  input  logic                   kill,
  output logic                   br_trigger,
  output logic [BRSEL_WIDTH-1:0] br_sel,
  output logic [63:0]            br_a,
  output logic [63:0]            br_pc,
  output logic [63:0]            br_imm,
  input  logic [63:0]            br_out,
  input  logic                   br_redirect_valid,
  input  logic                   br_data_ok,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_link,
  output logic                   out_taken,
  output logic [63:0]            out_target,
  output logic                   flush,
  output logic [EPOCH_W-1:0]     epoch,
  output logic                   wd_err
);

  br_state_e          state_q, state_d;
  br_req_t            req_q, in_req;
  logic               taken_q;
  logic [63:0]        target_q;
  logic               flush_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [63:0]        link;
  logic               accept, resp_hs, wait_ok;
  logic               wd_clr, wd_en, wd_expire;

  assign in_req  = '{brsel: in_brsel, pc: in_pc, rs1: in_rs1, imm: in_imm};
  assign link    = link_addr(req_q.pc);
  assign accept  = in_valid && in_ready;
  // kill outranks both the br response and the consumer handshake.
  assign wait_ok = (state_q == ST_WAIT) && br_data_ok && !kill;
  assign resp_hs = (state_q == ST_RESP) && out_ready && !kill;

  assign wd_clr = (state_q != ST_WAIT);
  assign wd_en  = (state_q == ST_WAIT) && !br_data_ok && !kill;

  br_ctrl_wdog #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire),
    .err    (wd_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid)                  state_d = ST_TRIG;
        ST_TRIG:                                state_d = ST_WAIT;
        ST_WAIT: if (br_data_ok || wd_expire)   state_d = ST_RESP;
        ST_RESP: if (out_ready)                 state_d = ST_IDLE;
        default:                                state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    br_trigger = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      ST_IDLE: in_ready   = !kill;
      ST_TRIG: br_trigger = 1'b1;
      ST_RESP: out_valid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      flush_q  <= 1'b0;
      epoch_q  <= '0;
    end else begin
      flush_q <= resp_hs && taken_q;
      if (accept) begin
        req_q <= in_req;
      end
      if (wait_ok) begin
        target_q <= br_out;
        taken_q  <= br_redirect_valid && (br_out != link);
      end else if (wd_expire) begin
        // No answer from br: fall through rather than redirect to a stale value.
        target_q <= link;
        taken_q  <= 1'b0;
      end
      if (resp_hs && taken_q) begin
        epoch_q <= epoch_q + EPOCH_W'(1);
      end
    end
  end

  assign br_sel     = req_q.brsel;
  assign br_a       = req_q.rs1;
  assign br_pc      = req_q.pc;
  assign br_imm     = req_q.imm;
  assign out_link   = out_valid ? link : '0;
  assign out_taken  = taken_q;
  assign out_target = target_q;
  assign flush      = flush_q;
  assign epoch      = epoch_q;

endmodule
